// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin owner of the UART TX FIFO write port.
// A grant lasts one message (req_last), cut short by burst limit or idle timeout.
//
// Ports:
//   HCLK, HRESETn   clock, async active-low reset
//   req_valid/data/last  NREQ byte-stream requesters (8-bit packed lanes)
//   req_ready       per-requester accept strobe (valid & ready = transfer)
//   fifo_full       TX FIFO full flag
//   fifo_wr/wdata   TX FIFO write port
//   grant           one-hot current owner, zero when idle
//   busy            a grant is held
//   timeout_err     one-cycle pulse after a grant is revoked by timeout
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16,
  parameter int TIMEOUT   = 64
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdata,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_err
);

  localparam int PW = $clog2(NREQ);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            to_q, to_d;

  logic            pick_vld;
  logic [PW-1:0]   pick_idx;
  logic            own_valid;
  logic            own_last;
  logic [7:0]      own_data;
  logic            wr;

  // Scan downward from ptr+NREQ to ptr+1 so the last hit,
  // i.e. the one nearest above ptr, wins.
  always_comb begin
    logic [PW-1:0] idx;
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    idx      = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = PW'((int'(ptr_q) + k) % NREQ);
      if (req_valid[idx]) begin
        pick_vld = 1'b1;
        pick_idx = idx;
      end
    end
  end

  // ptr always holds the owner index while LOCKED.
  assign own_valid = req_valid[ptr_q];
  assign own_last  = req_last[ptr_q];
  assign own_data  = req_data[{ptr_q, 3'b000} +: 8];

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ptr_d      = ptr_q;
    bcnt_d     = bcnt_q;
    tcnt_d     = tcnt_q;
    to_d       = 1'b0;
    req_ready  = '0;
    wr         = 1'b0;
    fifo_wdata = 8'h00;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCKED;
          grant_d = NREQ'(1) << pick_idx;
          ptr_d   = pick_idx;
          bcnt_d  = '0;
          tcnt_d  = '0;
        end
      end
      LOCKED: begin
        req_ready  = grant_q & {NREQ{~fifo_full}};
        wr         = own_valid & ~fifo_full;
        fifo_wdata = own_data;
        if (wr) begin
          bcnt_d = bcnt_q + BW'(1);
          tcnt_d = '0;
          // last and burst limit together still release once
          if (own_last ||
              (bcnt_q + BW'(1) == BW'(MAX_BURST))) begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else if (!own_valid) begin
          // a full FIFO with valid owner is a stall, not idleness
          if (tcnt_q == TW'(TIMEOUT - 1)) begin
            state_d = IDLE;
            grant_d = '0;
            to_d    = 1'b1;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NREQ - 1);
      bcnt_q  <= '0;
      tcnt_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
      tcnt_q  <= tcnt_d;
      to_q    <= to_d;
    end
  end

  assign fifo_wr     = wr;
  assign grant       = grant_q;
  assign busy        = (state_q == LOCKED);
  assign timeout_err = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration order, burst limit,
// backpressure, timeout and mid-message reset.
module tb_uart_tx_arbiter;

  localparam int N = 4;

  logic           HCLK = 1'b0;
  logic           HRESETn = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           fifo_full;
  logic           fifo_wr;
  logic [7:0]     fifo_wdata;
  logic [N-1:0]   grant;
  logic           busy;
  logic           timeout_err;

  uart_tx_arbiter #(
    .NREQ(N),
    .MAX_BURST(4),
    .TIMEOUT(8)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_last(req_last),
    .req_ready(req_ready),
    .fifo_full(fifo_full),
    .fifo_wr(fifo_wr),
    .fifo_wdata(fifo_wdata),
    .grant(grant),
    .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 HCLK = ~HCLK;

  int ncmp = 0;
  int nbad = 0;
  int cyc  = 0;

  logic [8:0] mem [N][16];
  int         rd [N];
  int         wr [N];
  logic [N-1:0] fire;

  logic [3:0] h_gnt [1024];
  logic [3:0] h_rdy [1024];
  logic       h_wr  [1024];
  logic       h_to  [1024];
  logic       h_bsy [1024];

  logic [7:0] l_dat [64];
  int         l_ln  [64];
  int         l_cyc [64];
  int         nlog;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int lane_of(input logic [3:0] g);
    for (int i = 0; i < N; i++)
      if (g[i]) return i;
    return -1;
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][wr[r]] = {l, d};
    wr[r]++;
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      if (rd[i] < wr[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = mem[i][rd[i]][7:0];
        req_last[i]        = mem[i][rd[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
  endtask

  // Sample at negedge, advance sources just after posedge.
  task automatic tick();
    @(negedge HCLK);
    if (cyc >= 1000) begin
      $display("FAIL cycle_budget: got %0d want <1000", cyc);
      $fatal(1);
    end
    h_gnt[cyc] = grant;
    h_rdy[cyc] = req_ready;
    h_wr[cyc]  = fifo_wr;
    h_to[cyc]  = timeout_err;
    h_bsy[cyc] = busy;
    fire = req_valid & req_ready;
    if (fifo_wr && nlog < 64) begin
      l_dat[nlog] = fifo_wdata;
      l_ln[nlog]  = lane_of(grant);
      l_cyc[nlog] = cyc;
      nlog++;
    end
    @(posedge HCLK);
    #1;
    cyc++;
    for (int i = 0; i < N; i++)
      if (fire[i]) rd[i]++;
    apply();
  endtask

  task automatic do_reset();
    HRESETn   = 1'b0;
    fifo_full = 1'b0;
    flush();
    apply();
    repeat (2) tick();
    HRESETn = 1'b1;
    tick();
  endtask

  initial begin
    int s;
    int acc;
    logic [7:0] exp_d [8];
    int         exp_l [8];

    fifo_full = 1'b0;
    nlog = 0;
    flush();
    apply();
    do_reset();

    // reset state
    chk("rst_grant", 32'(h_gnt[cyc-1]), 0);
    chk("rst_busy", 32'(h_bsy[cyc-1]), 0);
    chk("rst_ready", 32'(h_rdy[cyc-1]), 0);
    chk("rst_wr", 32'(h_wr[cyc-1]), 0);
    chk("rst_wdata", 32'(fifo_wdata), 0);
    chk("rst_to", 32'(h_to[cyc-1]), 0);

    // single message on req0
    s = cyc;
    push(0, 8'h41, 1'b0);
    push(0, 8'h42, 1'b0);
    push(0, 8'h43, 1'b1);
    apply();
    nlog = 0;
    repeat (6) tick();
    chk("t1_gnt_s", 32'(h_gnt[s]), 0);
    chk("t1_gnt_s1", 32'(h_gnt[s+1]), 32'h1);
    chk("t1_gnt_end", 32'(h_gnt[s+4]), 0);
    chk("t1_busy_end", 32'(h_bsy[s+4]), 0);
    chk("t1_nlog", 32'(nlog), 3);
    for (int k = 0; k < 3; k++) begin
      chk("t1_data", 32'(l_dat[k]), 32'h41 + 32'(k));
      chk("t1_lane", 32'(l_ln[k]), 0);
      chk("t1_cyc", 32'(l_cyc[k]), 32'(s + 1 + k));
    end

    // simultaneous req0/req2 after reset, twice
    do_reset();
    s = cyc;
    push(0, 8'h01, 1'b1);
    push(2, 8'h02, 1'b1);
    apply();
    nlog = 0;
    repeat (6) tick();
    push(0, 8'h03, 1'b1);
    push(2, 8'h04, 1'b1);
    apply();
    repeat (6) tick();
    chk("t2_nlog", 32'(nlog), 4);
    chk("t2_lane0", 32'(l_ln[0]), 0);
    chk("t2_lane1", 32'(l_ln[1]), 2);
    chk("t2_data1", 32'(l_dat[1]), 32'h02);
    chk("t2_cyc0", 32'(l_cyc[0]), 32'(s + 1));
    chk("t2_gap", 32'(l_cyc[1]), 32'(s + 3));
    chk("t2_lane2", 32'(l_ln[2]), 0);
    chk("t2_lane3", 32'(l_ln[3]), 2);
    chk("t2_data3", 32'(l_dat[3]), 32'h04);

    // backpressure mid-message, longer than the timeout
    s = cyc;
    push(1, 8'h10, 1'b0);
    push(1, 8'h11, 1'b0);
    push(1, 8'h12, 1'b1);
    apply();
    nlog = 0;
    repeat (2) tick();
    fifo_full = 1'b1;
    repeat (10) tick();
    fifo_full = 1'b0;
    repeat (5) tick();
    acc = 0;
    for (int c = s + 2; c <= s + 11; c++)
      acc += int'(h_wr[c]) + int'(h_rdy[c] != 4'h0);
    chk("t3_stall_quiet", 32'(acc), 0);
    acc = 0;
    for (int c = s; c <= s + 16; c++)
      acc += int'(h_to[c]);
    chk("t3_no_to", 32'(acc), 0);
    chk("t3_gnt_held", 32'(h_gnt[s+11]), 32'h2);
    chk("t3_nlog", 32'(nlog), 3);
    chk("t3_cyc1", 32'(l_cyc[1]), 32'(s + 12));
    chk("t3_data1", 32'(l_dat[1]), 32'h11);
    chk("t3_cyc2", 32'(l_cyc[2]), 32'(s + 13));

    // burst limit: req1 6 bytes, req3 waiting
    s = cyc;
    for (int k = 0; k < 6; k++)
      push(1, 8'h51 + 8'(k), k == 5);
    apply();
    nlog = 0;
    tick();
    push(3, 8'h71, 1'b0);
    push(3, 8'h72, 1'b1);
    apply();
    repeat (12) tick();
    exp_d = '{8'h51, 8'h52, 8'h53, 8'h54,
              8'h71, 8'h72, 8'h55, 8'h56};
    exp_l = '{1, 1, 1, 1, 3, 3, 1, 1};
    chk("t4_nlog", 32'(nlog), 8);
    for (int k = 0; k < 8; k++) begin
      chk("t4_data", 32'(l_dat[k]), 32'(exp_d[k]));
      chk("t4_lane", 32'(l_ln[k]), 32'(exp_l[k]));
    end
    chk("t4_gap", 32'(l_cyc[4]), 32'(l_cyc[3] + 2));

    // timeout: one byte without last, then silence
    s = cyc;
    push(2, 8'h99, 1'b0);
    apply();
    nlog = 0;
    repeat (14) tick();
    chk("t5_nlog", 32'(nlog), 1);
    chk("t5_wr_cyc", 32'(l_cyc[0]), 32'(s + 1));
    chk("t5_gnt_held", 32'(h_gnt[s+9]), 32'h4);
    chk("t5_to_early", 32'(h_to[s+9]), 0);
    chk("t5_to_pulse", 32'(h_to[s+10]), 1);
    chk("t5_to_after", 32'(h_to[s+11]), 0);
    chk("t5_gnt_rel", 32'(h_gnt[s+10]), 0);
    acc = 0;
    for (int c = s; c <= s + 13; c++)
      acc += int'(h_to[c]);
    chk("t5_to_once", 32'(acc), 1);

    // reset while LOCKED
    s = cyc;
    for (int k = 0; k < 4; k++)
      push(0, 8'hA0 + 8'(k), k == 3);
    apply();
    nlog = 0;
    repeat (2) tick();
    chk("t6_locked", 32'(busy), 1);
    HRESETn = 1'b0;
    #1;
    chk("t6_grant", 32'(grant), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_wr", 32'(fifo_wr), 0);
    chk("t6_wdata", 32'(fifo_wdata), 0);
    chk("t6_to", 32'(timeout_err), 0);
    flush();
    push(3, 8'hC3, 1'b1);
    push(0, 8'hB0, 1'b1);
    apply();
    repeat (2) tick();
    nlog = 0;
    HRESETn = 1'b1;
    repeat (6) tick();
    chk("t6_nlog", 32'(nlog), 2);
    chk("t6_first_lane", 32'(l_ln[0]), 0);
    chk("t6_first_data", 32'(l_dat[0]), 32'hB0);
    chk("t6_second_lane", 32'(l_ln[1]), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule
